// File: rtl/ai_qram_port.sv
// Read-only QRAM port: turns single-word address requests into fixed-latency RAM reads
// and returns the data in order through a small credit-controlled return FIFO.
module ai_qram_port #(
  parameter int AW     = 14,
  parameter int RD_LAT = 2,
  parameter int QD     = 4
) (
  input  logic          csi_clk,
  input  logic          rsi_reset_n,
  input  logic [31:0]   avs_s0_addr,
  input  logic          avs_s0_valid,
  output logic          avs_s0_ready,
  output logic [63:0]   avm_s1_dout,
  output logic          avm_s1_valid,
  input  logic          avm_s1_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [63:0]   mem_q,
  input  logic          err_clr,
  output logic          err_range,
  output logic [15:0]   req_cnt
);

  localparam int QW = $clog2(QD);
  localparam logic [7:0] QD_L = 8'(QD);

  logic              w_accept;
  logic              w_oor;
  logic              w_push;
  logic              w_pop;
  logic [63:0]       w_push_data;

  logic [RD_LAT-1:0] r_tag_v;
  logic [RD_LAT-1:0] r_tag_oor;
  logic [2:0]        r_inflight;
  logic [QW:0]       r_count;
  logic [QW-1:0]     r_wr_ptr;
  logic [QW-1:0]     r_rd_ptr;
  logic [63:0]       r_fifo [QD];
  logic              r_err;
  logic [15:0]       r_req_cnt;

  assign w_oor = |avs_s0_addr[31:AW];

  // Credit covers both reads still in the RAM pipe and words already queued,
  // so a push can never find the FIFO full.
  assign avs_s0_ready = rsi_reset_n && ((8'(r_inflight) + 8'(r_count)) < QD_L);
  assign w_accept     = avs_s0_valid && avs_s0_ready;

  assign mem_rd   = w_accept;
  assign mem_addr = avs_s0_addr[AW-1:0];

  assign w_push      = r_tag_v[RD_LAT-1];
  assign w_push_data = r_tag_oor[RD_LAT-1] ? 64'h0 : mem_q;

  assign avm_s1_valid = rsi_reset_n && (r_count != '0);
  assign avm_s1_dout  = rsi_reset_n ? r_fifo[r_rd_ptr] : 64'h0;
  assign w_pop        = avm_s1_valid && avm_s1_ready;

  assign err_range = r_err;
  assign req_cnt   = r_req_cnt;

  always_ff @(posedge csi_clk) begin
    if (!rsi_reset_n) begin
      r_tag_v    <= '0;
      r_tag_oor  <= '0;
      r_inflight <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_err      <= 1'b0;
      r_req_cnt  <= '0;
      for (int i = 0; i < QD; i++) r_fifo[i] <= '0;
    end else begin
      r_tag_v   <= (r_tag_v << 1) | RD_LAT'(w_accept);
      r_tag_oor <= (r_tag_oor << 1) | RD_LAT'(w_accept && w_oor);

      case ({w_accept, w_push})
        2'b10:   r_inflight <= r_inflight + 3'd1;
        2'b01:   r_inflight <= r_inflight - 3'd1;
        default: r_inflight <= r_inflight;
      endcase

      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_push_data;
        r_wr_ptr         <= r_wr_ptr + QW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + QW'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (QW+1)'(1);
        2'b01:   r_count <= r_count - (QW+1)'(1);
        default: r_count <= r_count;
      endcase

      // A new out-of-range accept takes priority over a clear in the same cycle.
      if (w_accept && w_oor) r_err <= 1'b1;
      else if (err_clr)      r_err <= 1'b0;

      if (w_accept && (r_req_cnt != 16'hFFFF)) r_req_cnt <= r_req_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ai_qram_port.sv
// Directed bench for ai_qram_port: behavioural RAM with 2-cycle latency, in-order
// scoreboard fed at request accept and drained at response handshake.
module tb_ai_qram_port;
  localparam int AW = 14;
  localparam int RD_LAT = 2;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   avs_s0_addr = '0;
  logic          avs_s0_valid = 1'b0;
  logic          avs_s0_ready;
  logic [63:0]   avm_s1_dout;
  logic          avm_s1_valid;
  logic          avm_s1_ready = 1'b1;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [63:0]   mem_q;
  logic          err_clr = 1'b0;
  logic          err_range;
  logic [15:0]   req_cnt;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] ram_p1 = '0, ram_p2 = '0;
  logic [63:0] prev_dout = '0;
  logic        prev_stall = 1'b0;

  always #5 clk = ~clk;

  ai_qram_port #(.AW(AW), .RD_LAT(RD_LAT), .QD(QD)) dut (
    .csi_clk(clk), .rsi_reset_n(rst_n),
    .avs_s0_addr(avs_s0_addr), .avs_s0_valid(avs_s0_valid), .avs_s0_ready(avs_s0_ready),
    .avm_s1_dout(avm_s1_dout), .avm_s1_valid(avm_s1_valid), .avm_s1_ready(avm_s1_ready),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_q(mem_q),
    .err_clr(err_clr), .err_range(err_range), .req_cnt(req_cnt)
  );

  function automatic logic [63:0] ram_word(input logic [13:0] a);
    if (a == 14'h10) return 64'hDEAD_BEEF_0123_4567;
    return {32'hC0DE_0000 | {18'h0, a}, 32'h5A5A_0000 ^ {18'h0, a}};
  endfunction

  // RAM model: data appears on mem_q two cycles after the read strobe.
  always @(posedge clk) begin
    ram_p1 <= mem_rd ? ram_word(mem_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
    ram_p2 <= ram_p1;
  end
  assign mem_q = ram_p2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (avs_s0_valid && avs_s0_ready)
        exp_q.push_back((avs_s0_addr[31:AW] != 0) ? 64'h0 : ram_word(avs_s0_addr[AW-1:0]));
      if (avm_s1_valid) begin
        if (prev_stall) check("stall_hold", avm_s1_dout, prev_dout);
        if (avm_s1_ready) begin
          check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) check("resp_order", avm_s1_dout, exp_q.pop_front());
        end
      end
      prev_stall = avm_s1_valid && !avm_s1_ready;
      prev_dout  = avm_s1_dout;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int acc;
    int cyc;

    // Reset state, with a request offered to show it is ignored.
    avs_s0_valid = 1'b1;
    avs_s0_addr  = 32'h10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", avs_s0_ready, 0);
    check("rst_valid", avm_s1_valid, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_dout", avm_s1_dout, 0);
    check("rst_req_cnt", req_cnt, 0);
    check("rst_err", err_range, 0);
    step();
    rst_n = 1'b1;
    avs_s0_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", avs_s0_ready, 1);

    // Single read and latency.
    step();
    avs_s0_valid = 1'b1;
    avs_s0_addr  = 32'h0000_0010;
    @(negedge clk);
    check("single_mem_rd", mem_rd, 1);
    check("single_mem_addr", mem_addr, 14'h10);
    step();
    avs_s0_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("single_latency", avm_s1_valid, (k == 3));
      if (k == 3) check("single_data", avm_s1_dout, 64'hDEAD_BEEF_0123_4567);
      step();
    end

    // Eight back-to-back reads, one response per cycle.
    for (int k = 0; k < 12; k++) begin
      avs_s0_valid = (k < 8);
      avs_s0_addr  = 32'(k);
      @(negedge clk);
      if (k < 8) check("b2b_ready", avs_s0_ready, 1);
      check("b2b_valid", avm_s1_valid, (k >= 3 && k <= 10));
      step();
    end
    check("b2b_drained", 64'(exp_q.size()), 0);

    // Back-pressure: only QD requests fit while the consumer stalls.
    avm_s1_ready = 1'b0;
    acc = 0;
    avs_s0_valid = 1'b1;
    avs_s0_addr  = 32'h100;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (avs_s0_ready) acc++;
      step();
      avs_s0_addr = 32'h100 + 32'(acc);
    end
    check("bp_accepted", 64'(acc), 4);
    @(negedge clk);
    check("bp_ready_low", avs_s0_ready, 0);
    check("bp_valid_high", avm_s1_valid, 1);
    step();
    avm_s1_ready = 1'b1;
    cyc = 0;
    while (acc < 6 && cyc < 20) begin
      @(negedge clk);
      if (avs_s0_ready) acc++;
      step();
      avs_s0_addr = 32'h100 + 32'(acc);
      cyc++;
    end
    avs_s0_valid = 1'b0;
    check("bp_rest_accepted", 64'(acc), 6);
    cyc = 0;
    while ((exp_q.size() != 0 || avm_s1_valid) && cyc < 20) begin
      step();
      cyc++;
    end
    check("bp_drained", 64'(exp_q.size()), 0);

    // Out-of-range requests and the sticky error flag.
    avs_s0_valid = 1'b1;
    avs_s0_addr  = 32'h0001_0000;
    @(negedge clk);
    check("oor_mem_rd", mem_rd, 1);
    check("oor_err_before", err_range, 0);
    step();
    avs_s0_valid = 1'b0;
    @(negedge clk);
    check("oor_err_set", err_range, 1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    check("oor_err_clr", err_range, 0);
    step();
    err_clr = 1'b1;
    avs_s0_valid = 1'b1;
    avs_s0_addr  = 32'h0002_0005;
    step();
    err_clr = 1'b0;
    avs_s0_valid = 1'b0;
    @(negedge clk);
    check("oor_set_wins", err_range, 1);
    repeat (6) step();
    check("oor_drained", 64'(exp_q.size()), 0);

    // Reset with requests in flight and queued.
    avm_s1_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      avs_s0_valid = 1'b1;
      avs_s0_addr  = 32'h20 + 32'(k);
      @(negedge clk);
      step();
    end
    avs_s0_valid = 1'b0;
    @(negedge clk);
    check("mid_valid_pre_rst", avm_s1_valid, 1);
    step();
    rst_n = 1'b0;
    exp_q.delete();
    avm_s1_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", avm_s1_valid, 0);
    check("mid_rst_ready", avs_s0_ready, 0);
    step();
    @(negedge clk);
    check("mid_rst_req_cnt", req_cnt, 0);
    check("mid_rst_err", err_range, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale", avm_s1_valid, 0);
      step();
    end
    avs_s0_valid = 1'b1;
    avs_s0_addr  = 32'h5;
    @(negedge clk);
    step();
    avs_s0_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 10) begin
      step();
      cyc++;
    end
    check("post_rst_read_done", 64'(exp_q.size()), 0);

    // Request counter saturation.
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    acc = 0;
    cyc = 0;
    avs_s0_valid = 1'b1;
    avs_s0_addr  = 32'h40;
    while (acc < 65540 && cyc < 70000) begin
      @(negedge clk);
      if (avs_s0_ready) acc++;
      if (acc == 65535) check("cnt_at_max_minus", req_cnt, 16'hFFFE);
      step();
      cyc++;
    end
    avs_s0_valid = 1'b0;
    check("sat_accepted", 64'(acc), 65540);
    @(negedge clk);
    check("sat_req_cnt", req_cnt, 16'hFFFF);
    repeat (8) step();
    check("sat_drained", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
